// File: rtl/hwpe_evt_irq_unit.sv
// hwpe_evt_irq_unit: turns per-core HWPE event pulses into maskable,
// coalescable, software-clearable interrupt lines behind a small
// 32-bit register slave on the hwpectrl bus.
module hwpe_evt_irq_unit #(
  parameter int unsigned NrCores      = 9,
  parameter int unsigned RegAddrWidth = 6,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NrCores-1:0]      hwpe_evt_i,
  input  logic                    reg_req_i,
  input  logic [RegAddrWidth-1:0] reg_addr_i,
  input  logic                    reg_we_i,
  input  logic [31:0]             reg_wdata_i,
  input  logic [3:0]              reg_be_i,
  output logic                    reg_gnt_o,
  output logic                    reg_rsp_valid_o,
  output logic [31:0]             reg_rsp_rdata_o,
  output logic [NrCores-1:0]      mxip_o
);

  // Word indices of the register map (byte offset divided by four)
  localparam logic [31:0] WordPending = 32'd0;
  localparam logic [31:0] WordEnable  = 32'd1;
  localparam logic [31:0] WordSet     = 32'd2;
  localparam logic [31:0] WordThresh  = 32'd3;
  localparam logic [31:0] WordCount0  = 32'd4;

  localparam logic [CntWidth-1:0] CountMax = {CntWidth{1'b1}};

  logic [NrCores-1:0]  r_pending;
  logic [NrCores-1:0]  r_enable;
  logic [7:0]          r_thresh;
  logic [7:0]          r_co    [NrCores];
  logic [CntWidth-1:0] r_count [NrCores];
  logic                r_rspValid;
  logic [31:0]         r_rspRdata;

  logic [31:0]         w_wordIdx;
  logic [31:0]         w_byteMask;
  logic [31:0]         w_wdataMasked;
  logic [NrCores-1:0]  w_wdataCore;
  logic                w_wrEn;
  logic                w_pendWr;
  logic                w_enableWr;
  logic                w_setWr;
  logic                w_threshWr;
  logic [NrCores-1:0]  w_countWr;
  logic [NrCores-1:0]  w_pendClr;
  logic [NrCores-1:0]  w_softSet;
  logic [NrCores-1:0]  w_hit;
  logic [7:0]          w_effThresh;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // Address bits [1:0] are ignored; only the word index selects a register
  assign w_wordIdx     = 32'(reg_addr_i[RegAddrWidth-1:2]);
  assign w_byteMask    = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}}, {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
  assign w_wdataMasked = reg_wdata_i & w_byteMask;
  assign w_wdataCore   = w_wdataMasked[NrCores-1:0];

  assign w_wrEn     = reg_req_i & reg_we_i;
  assign w_pendWr   = w_wrEn & (w_wordIdx == WordPending);
  assign w_enableWr = w_wrEn & (w_wordIdx == WordEnable);
  assign w_setWr    = w_wrEn & (w_wordIdx == WordSet);
  assign w_threshWr = w_wrEn & (w_wordIdx == WordThresh);

  assign w_pendClr = w_pendWr ? w_wdataCore : '0;
  assign w_softSet = w_setWr  ? w_wdataCore : '0;

  // A programmed threshold of zero coalesces like a threshold of one
  assign w_effThresh = (r_thresh == 8'd0) ? 8'd1 : r_thresh;

  assign reg_gnt_o       = 1'b1;
  assign reg_rsp_valid_o = r_rspValid;
  assign reg_rsp_rdata_o = r_rspRdata;
  assign mxip_o          = r_pending & r_enable;

  // Address and data bits that no register field consumes
  assign w_unused = ^{reg_addr_i[1:0], reg_wdata_i, w_byteMask};

  // Per-core threshold hit detection and COUNT_i write decode
  always_comb begin
    w_hit     = '0;
    w_countWr = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (hwpe_evt_i[i] && (({1'b0, r_co[i]} + 9'd1) >= {1'b0, w_effThresh})) begin
        w_hit[i] = 1'b1;
      end
      if (w_wrEn && (w_wordIdx == (WordCount0 + i))) begin
        w_countWr[i] = 1'b1;
      end
    end
  end

  // Pending, enable and threshold registers; a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_thresh  <= 8'd1;
    end else begin
      r_pending <= (r_pending & ~w_pendClr) | w_softSet | w_hit;
      if (w_enableWr) begin
        r_enable <= (r_enable & ~w_byteMask[NrCores-1:0]) | w_wdataCore;
      end
      if (w_threshWr && reg_be_i[0]) begin
        r_thresh <= reg_wdata_i[7:0];
      end
    end
  end

  // Coalescing counters restart on threshold hits and on any THRESH write;
  // total event counters saturate and a write forces them to this cycle's event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NrCores; i++) begin
        r_co[i]    <= 8'd0;
        r_count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NrCores; i++) begin
        if (w_threshWr || w_hit[i]) begin
          r_co[i] <= 8'd0;
        end else if (hwpe_evt_i[i]) begin
          r_co[i] <= r_co[i] + 8'd1;
        end

        if (w_countWr[i]) begin
          r_count[i] <= hwpe_evt_i[i] ? CntWidth'(1) : '0;
        end else if (hwpe_evt_i[i] && (r_count[i] != CountMax)) begin
          r_count[i] <= r_count[i] + CntWidth'(1);
        end
      end
    end
  end

  // Read data multiplexer, sampled in the request cycle
  always_comb begin
    w_rdata = '0;
    case (w_wordIdx)
      WordPending: w_rdata[NrCores-1:0] = r_pending;
      WordEnable:  w_rdata[NrCores-1:0] = r_enable;
      WordThresh:  w_rdata[7:0]         = r_thresh;
      default: begin
        for (int unsigned i = 0; i < NrCores; i++) begin
          if (w_wordIdx == (WordCount0 + i)) begin
            w_rdata = 32'(r_count[i]);
          end
        end
      end
    endcase
  end

  // Single-cycle response pipeline; writes answer with zero data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= reg_req_i;
      r_rspRdata <= (reg_req_i && !reg_we_i) ? w_rdata : '0;
    end
  end

endmodule
